spi_master_arbiter: RTL and testbench
=====================================

SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 Parameter: CLK_DIV, default 4, SCK half-period in clk cycles; legal range 2..255.
REQ-002 Parameter: GAP_DIV, default 2, CS-high guard time in units of CLK_DIV cycles; legal range 1..15.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  2  per-requester transaction request; bit i = requester i.
REQ-006 cmd0, addr0, wdata0  input  8 each  requester 0 frame fields.
REQ-007 cmd1, addr1, wdata1  input  8 each  requester 1 frame fields.
REQ-008 gnt  output  2  one-cycle pulse: request accepted, operands captured.
REQ-009 done  output  2  one-cycle pulse: granted transaction complete.
REQ-010 rdata  output  8  read data; valid only in the done cycle.
REQ-011 busy  output  1  high from the grant cycle through the done cycle.
REQ-012 cs  output  1  SPI chip select, active-low, idle high.
REQ-013 sck  output  1  SPI serial clock, idle low (mode 0).
REQ-014 mosi  output  1  master-out data, MSB first.
REQ-015 miso  input  1  slave-in data, sampled on the clk edge that drives sck high.

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP, SHIFT, GAP and DONE, all registered.
REQ-017 In IDLE, when req!=0, the block SHALL grant one requester, pulse gnt[i] and load the 24-bit frame {cmd,addr,wdata} into the TX shift register; it then enters SETUP.
REQ-018 Arbitration SHALL be round-robin: if both requests are high, the requester not served last wins; on a single request, that requester wins.
REQ-019 The round-robin pointer SHALL update only in DONE.
REQ-020 In SETUP, cs=0, sck=0 and mosi=frame bit 23 for exactly CLK_DIV cycles; the block then drives sck=1 and enters SHIFT.
REQ-021 In SHIFT, sck SHALL toggle every CLK_DIV cycles, for 24 high phases and 24 low phases.
REQ-022 On each sck rising edge, miso SHALL be shifted into a 24-bit RX register.
REQ-023 On each sck falling edge, mosi SHALL advance to the next frame bit; after the 24th falling edge, mosi=0.
REQ-024 A 5-bit bit counter SHALL count 0..23 and SHALL NOT wrap; after the 24th low phase the block SHALL enter GAP.
REQ-025 In GAP, cs=1, sck=0 and mosi=0 for GAP_DIV*CLK_DIV cycles; the block then enters DONE.
REQ-026 In DONE, the block SHALL pulse done[i] for the granted i for one cycle, drive rdata, and return to IDLE.
REQ-027 When the captured cmd==8'hFF (read), rdata SHALL equal RX[7:0], the bits sampled during frame bits 16..23.
REQ-028 For any other captured cmd, rdata SHALL be 8'h00.
REQ-029 Latency: done SHALL assert exactly 1 + CLK_DIV*(49 + GAP_DIV) cycles after the cycle in which req is sampled in IDLE (D=4, G=2: 205 cycles).
REQ-030 Requests SHALL be ignored outside IDLE; captured operands SHALL NOT change mid-frame.
REQ-031 A req still high in the done cycle SHALL be arbitrated no earlier than the following IDLE cycle.
REQ-032 Back-to-back frames SHALL therefore always see cs high for at least GAP_DIV*CLK_DIV+2 cycles.
REQ-033 gnt, done and busy SHALL never be asserted for both requesters at once.

Reset
REQ-034 On rst: state=IDLE, cs=1, sck=0, mosi=0, gnt=0, done=0, rdata=0, busy=0, and the round-robin pointer favours requester 0.
REQ-035 rst asserted mid-frame SHALL take effect on the next clk edge, with no done pulse; the aborted requester SHALL re-request.

Verification
REQ-036 Write: req=2'b01, cmd0=8'h01, addr0=8'h0A, wdata0=8'h5C -> mosi serialises 0x010A5C MSB-first across 24 sck rises, done[0] at cycle 205, rdata=8'h00.
REQ-037 Read: cmd0=8'hFF, addr0=8'h0A, slave model returns 8'hA5 on bits 16..23 -> rdata=8'hA5 with done[0].
REQ-038 Contention: req=2'b11 held continuously -> gnt sequence 0,1,0,1; each frame is separated by cs high for at least 10 cycles (D=4, G=2).
REQ-039 Mid-frame reset: rst pulsed at bit 10 -> next cycle cs=1, sck=0, mosi=0, busy=0, no done pulse; a new req=2'b10 is granted to requester 1.
REQ-040 Timing check: with CLK_DIV=2, sck high and low phases each measure 2 cycles, exactly 24 rises occur while cs=0, and miso is sampled on the rises only.

Source files
------------

// File: rtl/spi_master_arbiter_if.sv
// Bundle of request/response and SPI pin signals shared by the two-requester
// SPI master and whatever sits around it (requesters on one side, the SPI
// slave on the other). The master modport is the arbiter's view.
interface spi_master_arbiter_if;
    // requester side
    logic [1:0] req;
    logic [7:0] cmd0;
    logic [7:0] addr0;
    logic [7:0] wdata0;
    logic [7:0] cmd1;
    logic [7:0] addr1;
    logic [7:0] wdata1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [7:0] rdata;
    logic       busy;
    // SPI pins
    logic       cs;
    logic       sck;
    logic       mosi;
    logic       miso;

    modport master (
        input  req, cmd0, addr0, wdata0, cmd1, addr1, wdata1, miso,
        output gnt, done, rdata, busy, cs, sck, mosi
    );

    modport slave (
        output req, cmd0, addr0, wdata0, cmd1, addr1, wdata1, miso,
        input  gnt, done, rdata, busy, cs, sck, mosi
    );
endinterface

// File: rtl/spi_master_arbiter.sv
// Two-requester SPI mode-0 master. One 24-bit frame {cmd, addr, wdata} is
// shifted out per grant, MSB first; miso is captured on every sck rise and
// the last byte is returned as read data when cmd is 8'hFF. Requesters are
// served round-robin, and the pointer only moves once a frame completes.
module spi_master_arbiter #(
    parameter int unsigned CLK_DIV = 4,   // sck half-period in clk cycles (2..255)
    parameter int unsigned GAP_DIV = 2    // cs-high guard, in CLK_DIV units (1..15)
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_master_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_DIV - 1);
    localparam logic [4:0] BIT_LAST = 5'd23;
    localparam logic [7:0] CMD_READ = 8'hFF;

    state_t      state_q;
    logic [7:0]  div_q;     // clk cycles within the current half-period
    logic [3:0]  gap_q;     // half-periods elapsed in GAP
    logic [4:0]  bit_q;     // frame bit index, 0..23, never wraps
    logic [23:0] tx_q;      // outgoing frame; mosi is its MSB
    logic [23:0] rx_q;      // miso samples, newest in bit 0
    logic        rd_q;      // captured cmd was a read
    logic        owner_q;   // requester that owns the current frame
    logic        last_q;    // requester served most recently
    logic [1:0]  gnt_q;
    logic [1:0]  done_q;
    logic [7:0]  rdata_q;
    logic        busy_q;
    logic        cs_q;
    logic        sck_q;

    logic        win_d;
    logic [23:0] frame_d;
    logic        rd_d;
    logic [23:0] rx_d;
    logic        phase_end;

    // Only the last byte of the receive register is ever returned; the
    // upper bits are kept so the register holds the whole frame's samples.
    logic        rx_hi_unused;
    assign rx_hi_unused = ^rx_q[23:8];

    // Arbitration winner and the operands it would load, plus phase timing.
    always_comb begin
        win_d     = (bus.req == 2'b11) ? ~last_q : bus.req[1];
        frame_d   = win_d ? {bus.cmd1, bus.addr1, bus.wdata1}
                          : {bus.cmd0, bus.addr0, bus.wdata0};
        rd_d      = win_d ? (bus.cmd1 == CMD_READ) : (bus.cmd0 == CMD_READ);
        rx_d      = {rx_q[22:0], bus.miso};
        phase_end = (div_q == DIV_LAST);
    end

    // Frame sequencer: every output is a flop updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            gap_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rd_q    <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;    // so requester 0 wins the first contention
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.req != 2'b00) begin
                        gnt_q[win_d] <= 1'b1;
                        owner_q      <= win_d;
                        tx_q         <= frame_d;
                        rd_q         <= rd_d;
                        rx_q         <= '0;
                        busy_q       <= 1'b1;
                        cs_q         <= 1'b0;
                        sck_q        <= 1'b0;
                        div_q        <= '0;
                        bit_q        <= '0;
                        state_q      <= SETUP;
                    end
                end

                // mosi already shows bit 23; hold sck low one half-period.
                SETUP: begin
                    if (phase_end) begin
                        div_q   <= '0;
                        sck_q   <= 1'b1;
                        rx_q    <= rx_d;
                        state_q <= SHIFT;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end

                // Falls advance mosi (zero fill leaves mosi low after the
                // last bit); rises sample miso, except after the 24th low.
                SHIFT: begin
                    if (phase_end) begin
                        div_q <= '0;
                        if (sck_q) begin
                            sck_q <= 1'b0;
                            tx_q  <= {tx_q[22:0], 1'b0};
                        end else if (bit_q == BIT_LAST) begin
                            cs_q    <= 1'b1;
                            tx_q    <= '0;
                            gap_q   <= '0;
                            state_q <= GAP;
                        end else begin
                            bit_q <= bit_q + 5'd1;
                            sck_q <= 1'b1;
                            rx_q  <= rx_d;
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end

                // cs guard time before the frame is reported complete.
                GAP: begin
                    if (phase_end) begin
                        div_q <= '0;
                        if (gap_q == GAP_LAST) begin
                            done_q[owner_q] <= 1'b1;
                            rdata_q         <= rd_q ? rx_q[7:0] : 8'h00;
                            state_q         <= DONE;
                        end else begin
                            gap_q <= gap_q + 4'd1;
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end

                // Report cycle; the pointer moves here and nowhere else.
                DONE: begin
                    rdata_q <= '0;
                    busy_q  <= 1'b0;
                    last_q  <= owner_q;
                    state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign bus.cs    = cs_q;
    assign bus.sck   = sck_q;
    assign bus.mosi  = tx_q[23];

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: one instance at CLK_DIV=4/GAP_DIV=2 for the
// functional sequences, one at CLK_DIV=2 for sck phase timing. Stimulus
// pushes expected grants/completions into queues; per-instance monitor loops
// double as SPI slave models and pop/compare on gnt and done pulses.
module tb_spi_master_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master_arbiter_if bus0 ();
    spi_master_arbiter_if bus1 ();

    spi_master_arbiter #(.CLK_DIV(4), .GAP_DIV(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    spi_master_arbiter #(.CLK_DIV(2), .GAP_DIV(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    typedef struct {
        int          idx;
        logic [7:0]  rdata;
        int          cyc;
        logic [23:0] frame;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   gq0[$];

    logic [7:0]  sbyte0 = 8'h00;   // byte the slave returns on frame bits 16..23
    int          rise0 = 0;
    int          rise1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail_to(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Slave response: real data on the last eight rises, filler elsewhere.
    function automatic logic miso_bit(input int k, input logic [7:0] b);
        if (k >= 16 && k <= 23) return b[23-k];
        return k[0];
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic expect0(input int idx, input logic [7:0] rd, input int lat,
                           input logic [23:0] fr);
        exp_t e;
        e.idx = idx; e.rdata = rd; e.cyc = cyc + lat; e.frame = fr;
        sb0.push_back(e);
        gq0.push_back(idx);
    endtask

    task automatic wait_gnt(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (bus0.gnt == 2'b00 && n < budget);
        if (bus0.gnt == 2'b00) fail_to("wait_gnt");
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && n < budget) begin
            step();
            n++;
        end
        if (sb0.size() != 0 || sb1.size() != 0) begin
            fail_to("wait_done");
            sb0.delete();
            sb1.delete();
        end
        repeat (3) step();
    endtask

    // Instance 0: slave model, grant/done scoreboard, cs guard-time check.
    initial begin : mon0
        exp_t        e;
        logic [23:0] cap0 = '0;
        logic        cs0_p = 1'b1;
        logic        sck0_p = 1'b0;
        logic        armed0 = 1'b0;
        int          cs_hi0 = 0;
        bus0.miso = 1'b0;
        forever begin
            @(negedge clk);
            if (bus0.gnt != 2'b00) begin
                chk("gnt_onehot", 32'($countones(bus0.gnt)), 32'd1);
                if (gq0.size() == 0) chk("gnt_unexpected", 32'(bus0.gnt), 32'd0);
                else chk("gnt_idx", 32'(bus0.gnt[1]), 32'(gq0.pop_front()));
            end
            if (bus0.done != 2'b00) begin
                chk("done_onehot", 32'($countones(bus0.done)), 32'd1);
                chk("busy_in_done", 32'(bus0.busy), 32'd1);
                if (sb0.size() == 0) chk("done_unexpected", 32'(bus0.done), 32'd0);
                else begin
                    e = sb0.pop_front();
                    chk("done_idx", 32'(bus0.done[1]), 32'(e.idx));
                    chk("rdata", 32'(bus0.rdata), 32'(e.rdata));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("mosi_frame", 32'(cap0), 32'(e.frame));
                    chk("sck_rises", 32'(rise0), 32'd24);
                end
            end
            if (rst) armed0 = 1'b0;
            else if (!cs0_p && bus0.cs) begin
                armed0 = 1'b1;
                cs_hi0 = 0;
            end
            if (bus0.cs) cs_hi0++;
            if (cs0_p && !bus0.cs) begin
                if (armed0) chk("cs_gap_min", 32'(cs_hi0 >= 10), 32'd1);
                rise0 = 0;
                cap0  = '0;
            end
            if (!bus0.cs && bus0.sck && !sck0_p) begin
                cap0 = {cap0[22:0], bus0.mosi};
                rise0++;
            end
            cs0_p  = bus0.cs;
            sck0_p = bus0.sck;
            // Inverted during high phases, so a sample off the rising edge shows.
            bus0.miso = miso_bit(rise0, sbyte0) ^ bus0.sck;
        end
    end

    // Instance 1 (CLK_DIV=2): phase widths, rise count, read data.
    initial begin : mon1
        exp_t        e;
        logic [23:0] cap1 = '0;
        logic        cs1_p = 1'b1;
        logic        sck1_p = 1'b0;
        int          run1 = 0;
        bus1.miso = 1'b0;
        forever begin
            @(negedge clk);
            if (bus1.done != 2'b00) begin
                if (sb1.size() == 0) chk("done2_unexpected", 32'(bus1.done), 32'd0);
                else begin
                    e = sb1.pop_front();
                    chk("rdata2", 32'(bus1.rdata), 32'(e.rdata));
                    chk("done2_cycle", 32'(cyc), 32'(e.cyc));
                    chk("mosi_frame2", 32'(cap1), 32'(e.frame));
                    chk("sck_rises2", 32'(rise1), 32'd24);
                end
            end
            if (cs1_p && !bus1.cs) begin
                rise1 = 0;
                cap1  = '0;
                run1  = 1;
            end else if (!bus1.cs) begin
                if (bus1.sck != sck1_p) begin
                    if (sck1_p) chk("sck_high_w", 32'(run1), 32'd2);
                    else        chk("sck_low_w", 32'(run1), 32'd2);
                    run1 = 1;
                    if (bus1.sck) begin
                        cap1 = {cap1[22:0], bus1.mosi};
                        rise1++;
                    end
                end else begin
                    run1++;
                end
            end else if (!cs1_p && !rst) begin
                chk("sck_low_last", 32'(run1), 32'd2);
            end
            cs1_p  = bus1.cs;
            sck1_p = bus1.sck;
            bus1.miso = miso_bit(rise1, 8'h96) ^ bus1.sck;
        end
    end

    initial begin : stim
        int n;
        bus0.req = 2'b00; bus0.cmd0 = '0; bus0.addr0 = '0; bus0.wdata0 = '0;
        bus0.cmd1 = '0; bus0.addr1 = '0; bus0.wdata1 = '0;
        bus1.req = 2'b00; bus1.cmd0 = '0; bus1.addr0 = '0; bus1.wdata0 = '0;
        bus1.cmd1 = '0; bus1.addr1 = '0; bus1.wdata1 = '0;
        rst = 1'b1;
        repeat (3) step();
        chk("rst_cs",    32'(bus0.cs),    32'd1);
        chk("rst_sck",   32'(bus0.sck),   32'd0);
        chk("rst_mosi",  32'(bus0.mosi),  32'd0);
        chk("rst_gnt",   32'(bus0.gnt),   32'd0);
        chk("rst_done",  32'(bus0.done),  32'd0);
        chk("rst_rdata", 32'(bus0.rdata), 32'd0);
        chk("rst_busy",  32'(bus0.busy),  32'd0);
        rst = 1'b0;
        repeat (2) step();

        // Write on instance 0, read on the fast instance in parallel.
        bus0.cmd0 = 8'h01; bus0.addr0 = 8'h0A; bus0.wdata0 = 8'h5C; sbyte0 = 8'h3C;
        bus1.cmd0 = 8'hFF; bus1.addr0 = 8'h33; bus1.wdata0 = 8'h00;
        expect0(0, 8'h00, 205, 24'h010A5C);
        begin
            exp_t e2;
            e2.idx = 0; e2.rdata = 8'h96; e2.cyc = cyc + 103; e2.frame = 24'hFF3300;
            sb1.push_back(e2);
        end
        bus0.req = 2'b01; bus1.req = 2'b01;
        wait_gnt(10);
        bus0.req = 2'b00; bus1.req = 2'b00;
        wait_empty(400);

        // Read on requester 0.
        bus0.cmd0 = 8'hFF; bus0.addr0 = 8'h0A; bus0.wdata0 = 8'h00; sbyte0 = 8'hA5;
        expect0(0, 8'hA5, 205, 24'hFF0A00);
        bus0.req = 2'b01;
        wait_gnt(10);
        bus0.req = 2'b00;
        wait_empty(400);

        // Idle reset returns the pointer to requester 0 (it last served 0).
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Contention, request held: 0,1,0,1 back to back.
        bus0.cmd0 = 8'hFF; bus0.addr0 = 8'h11; bus0.wdata0 = 8'h22;
        bus0.cmd1 = 8'h02; bus0.addr1 = 8'h33; bus0.wdata1 = 8'h44; sbyte0 = 8'h5A;
        expect0(0, 8'h5A, 205, 24'hFF1122);
        expect0(1, 8'h00, 411, 24'h023344);
        expect0(0, 8'h5A, 617, 24'hFF1122);
        expect0(1, 8'h00, 823, 24'h023344);
        bus0.req = 2'b11;
        for (int g = 0; g < 4; g++) wait_gnt(300);
        bus0.req = 2'b00;
        wait_empty(1000);

        // Requester 1 alone, cmd one below the read code.
        bus0.cmd1 = 8'hFE; bus0.addr1 = 8'h5A; bus0.wdata1 = 8'hA5; sbyte0 = 8'hC3;
        expect0(1, 8'h00, 205, 24'hFE5AA5);
        bus0.req = 2'b10;
        wait_gnt(10);
        bus0.req = 2'b00;
        wait_empty(400);

        // Reset while bit 10 is on the wire: no completion for that frame.
        bus0.cmd0 = 8'h01; bus0.addr0 = 8'h22; bus0.wdata0 = 8'h33;
        gq0.push_back(0);
        bus0.req = 2'b01;
        wait_gnt(10);
        bus0.req = 2'b00;
        n = 0;
        while (rise0 < 11 && n < 200) begin
            step();
            n++;
        end
        if (rise0 < 11) fail_to("wait_bit10");
        rst = 1'b1;
        step();
        chk("abort_cs",   32'(bus0.cs),   32'd1);
        chk("abort_sck",  32'(bus0.sck),  32'd0);
        chk("abort_mosi", 32'(bus0.mosi), 32'd0);
        chk("abort_busy", 32'(bus0.busy), 32'd0);
        chk("abort_done", 32'(bus0.done), 32'd0);
        rst = 1'b0;
        repeat (250) step();

        // Requester 1 after the abort.
        bus0.cmd1 = 8'hFF; bus0.addr1 = 8'h0B; bus0.wdata1 = 8'h00; sbyte0 = 8'hE7;
        expect0(1, 8'hE7, 205, 24'hFF0B00);
        bus0.req = 2'b10;
        wait_gnt(10);
        bus0.req = 2'b00;
        wait_empty(400);

        if (gq0.size() != 0) fail_to("grants_outstanding");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
